multicycle_alu: RTL

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/alu_pkg.sv | 26 ++
 rtl/mul_seq_unit.sv | 69 ++++++
 rtl/multicycle_alu.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the multicycle ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_NEGA = 3'b000,
        OP_NEGB = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_MUL  = 3'b110,
        OP_XOR  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Opcodes 000-011 go through the shared adder and produce carry/overflow.
    function automatic logic is_arith(input op_e op_v);
        return (op_v[2] == 1'b0);
    endfunction

endpackage

// File: rtl/mul_seq_unit.sv
// Unsigned shift-add multiplier: one iteration per cycle, WIDTH iterations per product.
// done_o marks the cycle whose closing edge commits the final iteration; product_o is that value.
module mul_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic                 busy_q, busy_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH:0]       partial_s;
    logic [2*WIDTH-1:0]   step_s;
    logic                 last_s;

    // Upper half accumulates the partial sum; lower half shifts out multiplier bits.
    always_comb begin
        partial_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        step_s    = {partial_s, acc_q[WIDTH-1:1]};
        last_s    = busy_q && (cnt_q == CW'(WIDTH - 1));
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        if (start_i) begin
            busy_d  = 1'b1;
            cnt_d   = {CW{1'b0}};
            mcand_d = a_i;
            acc_d   = {{WIDTH{1'b0}}, b_i};
        end else if (busy_q) begin
            acc_d  = step_s;
            cnt_d  = cnt_q + CW'(1);
            busy_d = !last_s;
        end else begin
            busy_d = 1'b0;
        end
    end

    // Iteration state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            mcand_q <= {WIDTH{1'b0}};
            acc_q   <= {(2*WIDTH){1'b0}};
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
        end
    end

    assign done_o    = last_s;
    assign product_o = step_s;

endmodule

// File: rtl/multicycle_alu.sv
// Handshaked ALU: single-cycle adder/logic ops, WIDTH-cycle sequential multiply.
// Results and flags are registered and held in DONE until the consumer takes them.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   result_hi,
    output logic               flag_c,
    output logic               flag_v,
    output logic               flag_z
);

    state_e               state_q, state_d;
    op_e                  op_s;
    logic                 in_ready_s, out_valid_s, accept_s, mul_start_s, mul_done_s;
    logic [WIDTH-1:0]     x_s, y_s, logic_s, alu_res_s;
    logic                 cin_s, alu_c_s, alu_v_s;
    logic [WIDTH:0]       sum_s;
    logic [2*WIDTH-1:0]   product_s;
    logic [WIDTH-1:0]     result_q, result_hi_q;
    logic                 flag_c_q, flag_v_q, flag_z_q;

    assign op_s        = op_e'(op);
    assign accept_s    = in_valid && in_ready_s;
    assign mul_start_s = accept_s && (op_s == OP_MUL);

    mul_seq_unit #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start_s),
        .a_i       (a),
        .b_i       (b),
        .done_o    (mul_done_s),
        .product_o (product_s)
    );

    // Adder operand selection: negation and subtraction reuse one carry-in adder.
    always_comb begin
        x_s     = {WIDTH{1'b0}};
        y_s     = {WIDTH{1'b0}};
        cin_s   = 1'b0;
        logic_s = {WIDTH{1'b0}};
        case (op_s)
            OP_NEGA: begin x_s = ~a;               cin_s = 1'b1; end
            OP_NEGB: begin y_s = ~b;               cin_s = 1'b1; end
            OP_ADD:  begin x_s = a;  y_s = b;      cin_s = 1'b0; end
            OP_SUB:  begin x_s = a;  y_s = ~b;     cin_s = 1'b1; end
            OP_AND:  logic_s = a & b;
            OP_OR:   logic_s = a | b;
            OP_XOR:  logic_s = a ^ b;
            default: logic_s = {WIDTH{1'b0}};
        endcase
        sum_s = {1'b0, x_s} + {1'b0, y_s} + {{WIDTH{1'b0}}, cin_s};
        if (is_arith(op_s)) begin
            alu_res_s = sum_s[WIDTH-1:0];
            alu_c_s   = sum_s[WIDTH];
            alu_v_s   = (x_s[WIDTH-1] == y_s[WIDTH-1]) && (sum_s[WIDTH-1] != x_s[WIDTH-1]);
        end else begin
            alu_res_s = logic_s;
            alu_c_s   = 1'b0;
            alu_v_s   = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = (op_s == OP_MUL) ? ST_MUL : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_done_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output decode.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_q)
            ST_IDLE: in_ready_s  = 1'b1;
            ST_MUL:  in_ready_s  = 1'b0;
            ST_DONE: out_valid_s = 1'b1;
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Result/flag registers: loaded at a non-MUL accept or on the last multiply iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q    <= {WIDTH{1'b0}};
            result_hi_q <= {WIDTH{1'b0}};
            flag_c_q    <= 1'b0;
            flag_v_q    <= 1'b0;
            flag_z_q    <= 1'b0;
        end else if (accept_s && (op_s != OP_MUL)) begin
            result_q    <= alu_res_s;
            result_hi_q <= {WIDTH{1'b0}};
            flag_c_q    <= alu_c_s;
            flag_v_q    <= alu_v_s;
            flag_z_q    <= (alu_res_s == {WIDTH{1'b0}});
        end else if ((state_q == ST_MUL) && mul_done_s) begin
            result_q    <= product_s[WIDTH-1:0];
            result_hi_q <= product_s[2*WIDTH-1:WIDTH];
            flag_c_q    <= 1'b0;
            flag_v_q    <= (product_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
            flag_z_q    <= (product_s[WIDTH-1:0] == {WIDTH{1'b0}});
        end else begin
            result_q    <= result_q;
            result_hi_q <= result_hi_q;
            flag_c_q    <= flag_c_q;
            flag_v_q    <= flag_v_q;
            flag_z_q    <= flag_z_q;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign flag_c    = flag_c_q;
    assign flag_v    = flag_v_q;
    assign flag_z    = flag_z_q;

endmodule
